btb_predictor: RTL and testbench

- Parametrised branch target buffer for the RISC-V pipeline, with compressed-instruction (RVC) support.
- Stage 1 looks up the fetch PC and gets a taken/target prediction in the same cycle.
- Stage 3 supplies the resolved branch outcome, which updates the table and drives the flush/redirect back to fetch.
- Compared with the previous fixed BTB, it adds:
  - N-bit saturating confidence counters and tag checking;
  - halfword-granular indexing for 16-bit instructions;
  - target-mismatch detection;
  - saturating performance counters.

---
 rtl/btb_predictor.sv | 110 +++++++++++
 tb/tb_btb_predictor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with confidence counters and RVC-aware indexing
module btb_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int PC_W     = 32,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memory_stall,
    input  logic [PC_W-1:0]   pc_f,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic              res_is_c,
    input  logic              res_taken,
    input  logic [PC_W-1:0]   res_target,
    input  logic              res_pred_taken,
    input  logic [PC_W-1:0]   res_pred_target,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

    logic                ent_valid  [ENTRIES];
    logic [TAG_W-1:0]    ent_tag    [ENTRIES];
    logic [PC_W-1:0]     ent_target [ENTRIES];
    logic [CNT_BITS-1:0] ent_cnt    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             mis;
    logic             upd;
    logic             unused_pc_lsb;

    // Bit 0 never selects an entry: entries are halfword-granular for RVC.
    assign f_idx = pc_f[IDX_W:1];
    assign f_tag = pc_f[PC_W-1:IDX_W+1];
    assign r_idx = res_pc[IDX_W:1];
    assign r_tag = res_pc[PC_W-1:IDX_W+1];
    assign unused_pc_lsb = ^{pc_f[0], res_pc[0]};

    assign f_hit = ent_valid[f_idx] && (ent_tag[f_idx] == f_tag);
    assign r_hit = ent_valid[r_idx] && (ent_tag[r_idx] == r_tag);

    assign pred_taken  = ~rst & f_hit & ent_cnt[f_idx][CNT_BITS-1];
    assign pred_target = pred_taken ? ent_target[f_idx] : '0;

    assign mis = res_valid & ((res_taken != res_pred_taken) |
                              (res_taken & res_pred_taken & (res_target != res_pred_target)));
    assign flush = mis & ~rst;

    always_comb begin
        redirect_pc = '0;
        if (!rst) begin
            redirect_pc = res_taken ? res_target
                                    : res_pc + (res_is_c ? PC_W'(2) : PC_W'(4));
        end
    end

    assign upd = res_valid & ~memory_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i]  <= 1'b0;
                ent_tag[i]    <= '0;
                ent_target[i] <= '0;
                ent_cnt[i]    <= '0;
            end
        end else if (upd) begin
            if (r_hit) begin
                if (res_taken) begin
                    if (ent_cnt[r_idx] != CNT_MAX) ent_cnt[r_idx] <= ent_cnt[r_idx] + CNT_BITS'(1);
                    ent_target[r_idx] <= res_target;
                end else if (ent_cnt[r_idx] != '0) begin
                    ent_cnt[r_idx] <= ent_cnt[r_idx] - CNT_BITS'(1);
                end
            end else if (res_taken) begin
                // Allocation overwrites whatever branch aliases to this index.
                ent_valid[r_idx]  <= 1'b1;
                ent_tag[r_idx]    <= r_tag;
                ent_target[r_idx] <= res_target;
                ent_cnt[r_idx]    <= CNT_WEAK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + PERF_W'(1);
            if (mis && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor
module tb_btb_predictor;

    localparam int PC_W   = 32;
    localparam int PERF_W = 4;

    localparam int S_PT  = 0;
    localparam int S_PTG = 1;
    localparam int S_FL  = 2;
    localparam int S_RD  = 3;
    localparam int S_BC  = 4;
    localparam int S_MC  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              memory_stall;
    logic [PC_W-1:0]   pc_f;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              res_valid;
    logic [PC_W-1:0]   res_pc;
    logic              res_is_c;
    logic              res_taken;
    logic [PC_W-1:0]   res_target;
    logic              res_pred_taken;
    logic [PC_W-1:0]   res_pred_target;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispred_cnt;

    btb_predictor #(.ENTRIES(16), .CNT_BITS(2), .PC_W(PC_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst), .memory_stall(memory_stall),
        .pc_f(pc_f), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_c(res_is_c),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_PT:    return {31'd0, pred_taken};
            S_PTG:   return pred_target;
            S_FL:    return {31'd0, flush};
            S_RD:    return redirect_pc;
            S_BC:    return 32'(branch_cnt);
            default: return 32'(mispred_cnt);
        endcase
    endfunction

    task automatic push_exp(input int sel, input string tag, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Called just after a rising edge; the resolve commits on the next edge.
    task automatic resolve(input string tag, input logic [31:0] pc, input logic is_c,
                           input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt,
                           input logic exp_flush, input logic [31:0] exp_redir);
        res_valid = 1'b1; res_pc = pc; res_is_c = is_c; res_taken = taken;
        res_target = tgt; res_pred_taken = ptaken; res_pred_target = ptgt;
        push_exp(S_FL, {tag, "_flush"}, {31'd0, exp_flush});
        if (exp_flush) push_exp(S_RD, {tag, "_redir"}, exp_redir);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        res_valid = 1'b0; res_is_c = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_t_,
                          input logic [31:0] exp_tgt);
        pc_f = pc;
        push_exp(S_PT, {tag, "_pt"}, {31'd0, exp_t_});
        push_exp(S_PTG, {tag, "_ptg"}, exp_tgt);
        @(negedge clk);
        drain();
    endtask

    task automatic counters(input string tag, input int bc, input int mc);
        push_exp(S_BC, {tag, "_bcnt"}, 32'(bc));
        push_exp(S_MC, {tag, "_mcnt"}, 32'(mc));
        @(negedge clk);
        drain();
    endtask

    initial begin
        rst = 1'b1; memory_stall = 1'b0; pc_f = 32'h100;
        res_valid = 1'b1; res_pc = 32'h100; res_is_c = 1'b0; res_taken = 1'b1;
        res_target = 32'h200; res_pred_taken = 1'b0; res_pred_target = '0;

        // Reset gates flush even with a mispredicting resolve present.
        push_exp(S_PT, "rst_pt", 32'd0);
        push_exp(S_FL, "rst_flush", 32'd0);
        push_exp(S_RD, "rst_redir", 32'd0);
        push_exp(S_BC, "rst_bcnt", 32'd0);
        push_exp(S_MC, "rst_mcnt", 32'd0);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0; res_valid = 1'b0;

        lookup("cold_miss", 32'h100, 1'b0, 32'h0);
        @(posedge clk); #1;
        resolve("alloc", 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        lookup("alloc_hit", 32'h100, 1'b1, 32'h200);
        counters("alloc", 1, 1);
        @(posedge clk); #1;

        resolve("nt1", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        lookup("cnt1", 32'h100, 1'b0, 32'h0);
        @(posedge clk); #1;
        resolve("tk1", 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        resolve("tk2", 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
        resolve("tk3", 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
        resolve("nt2", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        lookup("sat_hyst", 32'h100, 1'b1, 32'h200);
        counters("hyst", 6, 4);
        @(posedge clk); #1;

        resolve("rvc", 32'h102, 1'b1, 1'b0, 32'h0, 1'b1, 32'h180, 1'b1, 32'h104);
        lookup("rvc_nomod", 32'h102, 1'b0, 32'h0);
        @(posedge clk); #1;
        resolve("tmis", 32'h100, 1'b0, 1'b1, 32'h340, 1'b1, 32'h300, 1'b1, 32'h340);
        lookup("tmis_upd", 32'h100, 1'b1, 32'h340);
        @(posedge clk); #1;

        resolve("alias", 32'h140, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
        lookup("alias_old", 32'h100, 1'b0, 32'h0);
        lookup("alias_new", 32'h140, 1'b1, 32'h500);
        counters("alias", 9, 7);
        @(posedge clk); #1;

        // Same-cycle lookup of the index being allocated sees the old entry.
        pc_f = 32'h180;
        push_exp(S_PT, "nobypass_pt", 32'd0);
        resolve("nobypass", 32'h180, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 32'h600);
        lookup("nobypass_after", 32'h180, 1'b1, 32'h600);
        @(posedge clk); #1;

        memory_stall = 1'b1;
        resolve("stall", 32'h200, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 32'h700);
        memory_stall = 1'b0;
        lookup("stall_tbl", 32'h200, 1'b0, 32'h0);
        counters("stall", 10, 8);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            resolve("fill", 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        counters("perf_sat", 15, 8);
        @(posedge clk); #1;
        resolve("fill2", 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        counters("perf_hold", 15, 8);

        // Asynchronous reset between edges, with a mispredict on the inputs.
        pc_f = 32'h180;
        res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; res_target = 32'h800;
        res_pred_taken = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        push_exp(S_PT, "arst_pt", 32'd0);
        push_exp(S_PTG, "arst_ptg", 32'd0);
        push_exp(S_FL, "arst_flush", 32'd0);
        push_exp(S_BC, "arst_bcnt", 32'd0);
        push_exp(S_MC, "arst_mcnt", 32'd0);
        drain();
        @(posedge clk); #1;
        rst = 1'b0; res_valid = 1'b0;
        lookup("post_rst_a", 32'h180, 1'b0, 32'h0);
        lookup("post_rst_b", 32'h100, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
